sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 10 +
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_arbiter_rr_arbiter.sv | 26 ++
 rtl/sram_arbiter.sv | 115 +++++++++++
 tb/tb_sram_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared defaults and FSM encodings for the SRAM arbiter.
package sram_arbiter_pkg;
    localparam int NUM_REQ_DEF = 2;
    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 128;
    localparam int LEN_W_DEF   = 8;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_RD_BURST = 1'b1;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus: per-requester request lanes plus the shared read response.
interface sram_arbiter_if
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_len, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_len, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, returned as a one-hot grant.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] gnt_dbl;
    logic [NUM_REQ-1:0]   rot_gnt;

    // Rotate so ptr sits at bit 0, pick the lowest set bit, rotate back.
    assign req_dbl = {req, req} >> ptr;

    always_comb begin
        rot_gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_dbl[k] && (rot_gnt == '0)) rot_gnt[k] = 1'b1;
        end
    end

    assign gnt_dbl = {{NUM_REQ{1'b0}}, rot_gnt} << ptr;
    assign grant   = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];
endmodule

// File: rtl/sram_arbiter.sv
// Shares one dual-port SRAM among NUM_REQ requesters: single-beat writes on port A,
// read bursts on port B, round-robin arbitration, owner-tagged read responses.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sram_arbiter_if.slave     bus,
    output logic              sram_ena,
    output logic              sram_wea,
    output logic [ADDR_W-1:0] sram_addra,
    output logic [DATA_W-1:0] sram_dina,
    output logic              sram_enb,
    output logic [ADDR_W-1:0] sram_addrb,
    input  logic [DATA_W-1:0] sram_doutb
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [0:0]                    state_q, state_d;
    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]              cnt_q, cnt_d;
    logic [ADDR_W-1:0]             addrb_q, addrb_d;
    logic [ADDR_W-1:0]             addra_q, addra_d;
    logic [DATA_W-1:0]             dina_q, dina_d;
    logic                          ena_q, ena_d;
    // Stage 0: owner of the beat on port B this cycle; stage 1: owner of the returning data.
    logic [1:0][NUM_REQ-1:0]       tag_pipe_q, tag_pipe_d;

    logic [NUM_REQ-1:0]            grant;
    logic [PTR_W-1:0]              gnt_idx;
    logic                          accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign bus.req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;
    assign accept        = |bus.req_ready;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) gnt_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        addrb_d       = addrb_q;
        addra_d       = addra_q;
        dina_d        = dina_q;
        ena_d         = 1'b0;
        tag_pipe_d[0] = '0;
        tag_pipe_d[1] = tag_pipe_q[0];
        if (state_q == ST_RD_BURST) begin
            tag_pipe_d[0] = tag_pipe_q[0];
            addrb_d       = addrb_q + 1'b1;
            cnt_d         = cnt_q - 1'b1;
            // Drop to IDLE as the last beat issues so the next grant can overlap it.
            if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
        end else if (accept) begin
            rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (bus.req_we[gnt_idx]) begin
                ena_d   = 1'b1;
                addra_d = bus.req_addr[gnt_idx];
                dina_d  = bus.req_wdata[gnt_idx];
            end else begin
                tag_pipe_d[0] = grant;
                addrb_d       = bus.req_addr[gnt_idx];
                cnt_d         = bus.req_len[gnt_idx];
                state_d       = (bus.req_len[gnt_idx] != '0) ? ST_RD_BURST : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            addrb_q    <= '0;
            addra_q    <= '0;
            dina_q     <= '0;
            ena_q      <= 1'b0;
            tag_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            addrb_q    <= addrb_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            ena_q      <= ena_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    assign sram_ena      = ena_q;
    assign sram_wea      = ena_q;
    assign sram_addra    = addra_q;
    assign sram_dina     = dina_q;
    assign sram_enb      = |tag_pipe_q[0];
    assign sram_addrb    = addrb_q;
    assign bus.rsp_valid = tag_pipe_q[1];
    assign bus.rsp_rdata = (|tag_pipe_q[1]) ? sram_doutb : '0;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM on both ports.
module tb_sram_arbiter;
    localparam int NR = 2, AW = 12, DW = 128, LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sram_ena, sram_wea, sram_enb;
    logic [AW-1:0] sram_addra, sram_addrb;
    logic [DW-1:0] sram_dina, sram_doutb;

    always #5 clk = ~clk;

    sram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    sram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_ena   (sram_ena),
        .sram_wea   (sram_wea),
        .sram_addra (sram_addra),
        .sram_dina  (sram_dina),
        .sram_enb   (sram_enb),
        .sram_addrb (sram_addrb),
        .sram_doutb (sram_doutb)
    );

    logic [DW-1:0] mem [0:4095];
    logic [DW-1:0] shd [0:4095];

    always @(posedge clk) begin
        if (sram_ena && sram_wea) mem[sram_addra] <= sram_dina;
        if (sram_enb) sram_doutb <= mem[sram_addrb];
    end

    typedef struct { logic [NR-1:0] own; logic [DW-1:0] data; int cyc; } rsp_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;

    rsp_t          rsp_q[$];
    wr_t           wr_q[$];
    logic [AW-1:0] ab_q[$];
    rsp_t          r_tmp;
    wr_t           w_tmp;
    logic [AW-1:0] a_tmp;
    logic [NR-1:0] oh_tmp;
    logic [NR-1:0] hs_seen = '0;
    int            n_tests = 0, n_fail = 0, cyc = 0, run = 0, last_run = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        return {4{(32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire expected events as the DUT produces them, enqueue new ones on handshakes.
    always @(negedge clk) begin
        if (rst) begin
            rsp_q.delete(); wr_q.delete(); ab_q.delete();
            hs_seen = '0;
            run     = 0;
            chk("rst_enb", sram_enb, 0);
            chk("rst_ena", sram_ena, 0);
            chk("rst_rsp", bus.rsp_valid, 0);
            chk("rst_rdy", bus.req_ready, 0);
        end else begin
            chk("rdy_onehot", $onehot0(bus.req_ready), 1);
            if (sram_ena) begin
                chk("wr_wea", sram_wea, 1);
                chk("wr_rd_same_cycle", sram_enb, 0);
                if (wr_q.size() == 0) chk("wr_unexpected", sram_ena, 0);
                else begin
                    w_tmp = wr_q.pop_front();
                    chk("wr_addr", sram_addra, w_tmp.addr);
                    chk("wr_data", sram_dina, w_tmp.data);
                    chk("wr_cyc", cyc, w_tmp.cyc);
                end
            end
            if (sram_enb) begin
                run++;
                if (ab_q.size() == 0) chk("rd_unexpected", sram_enb, 0);
                else chk("rd_addr", sram_addrb, ab_q.pop_front());
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
            if (bus.rsp_valid != '0) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
                else begin
                    r_tmp = rsp_q.pop_front();
                    chk("rsp_owner", bus.rsp_valid, r_tmp.own);
                    chk("rsp_data", bus.rsp_rdata, r_tmp.data);
                    chk("rsp_cyc", cyc, r_tmp.cyc);
                end
            end
            hs_seen = bus.req_valid & bus.req_ready;
            for (int i = 0; i < NR; i++) begin
                if (hs_seen[i]) begin
                    if (bus.req_we[i]) begin
                        wr_q.push_back('{bus.req_addr[i], bus.req_wdata[i], cyc + 1});
                        shd[bus.req_addr[i]] = bus.req_wdata[i];
                    end else begin
                        oh_tmp    = '0;
                        oh_tmp[i] = 1'b1;
                        for (int k = 0; k <= int'(bus.req_len[i]); k++) begin
                            a_tmp = bus.req_addr[i] + AW'(k);
                            ab_q.push_back(a_tmp);
                            rsp_q.push_back('{oh_tmp, shd[a_tmp], cyc + 2 + k});
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [LW-1:0] len, input logic [DW-1:0] d);
        bus.req_we[i]    = we;
        bus.req_addr[i]  = a;
        bus.req_len[i]   = len;
        bus.req_wdata[i] = d;
        bus.req_valid[i] = 1'b1;
    endtask

    // Called at posedge+#1 right after raising valids; drops each valid once it transfers.
    task automatic wait_accept();
        int n = 0;
        while (bus.req_valid != '0 && n < 50) begin
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~hs_seen;
            n++;
        end
        if (bus.req_valid != '0) begin
            chk("accept_timeout", bus.req_valid, 0);
            bus.req_valid = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() + wr_q.size() + ab_q.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", rsp_q.size() + wr_q.size() + ab_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = pat(i);
            shd[i] = pat(i);
        end
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.req_wdata = '0;

        // Reset: requests held during reset get no ready, idle bus stays quiet.
        repeat (2) @(posedge clk);
        #1 bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_rdy_with_valid", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_rdy", bus.req_ready, 0);
            chk("idle_enb", sram_enb, 0);
            chk("idle_ena", sram_ena, 0);
            chk("idle_rsp", bus.rsp_valid, 0);
        end

        // Write then read back the same word.
        @(posedge clk); #1;
        set_req(0, 1'b1, 12'h010, 8'd0, {16{8'hA5}});
        @(negedge clk);
        chk("first_rdy", bus.req_ready, 2'b01);
        wait_accept();
        set_req(1, 1'b0, 12'h010, 8'd0, '0);
        wait_accept();
        drain();
        chk("wr_rd_mem", mem[12'h010], {16{8'hA5}});

        // Fairness: both requesters keep writes pending.
        pulse_rst();
        set_req(0, 1'b1, 12'h100, 8'd0, pat(1));
        set_req(1, 1'b1, 12'h101, 8'd0, pat(2));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fair_gnt", bus.req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        drain();

        // Address wrap across the top of the SRAM.
        set_req(1, 1'b0, 12'hFFE, 8'd3, '0);
        wait_accept();
        drain();
        chk("wrap_run", last_run, 4);

        // Back-to-back bursts from both requesters.
        set_req(0, 1'b0, 12'h040, 8'd1, '0);
        set_req(1, 1'b0, 12'h080, 8'd2, '0);
        wait_accept();
        drain();
        chk("b2b_run", last_run, 5);

        // Reset in the middle of a long burst.
        set_req(0, 1'b0, 12'h300, 8'd7, '0);
        wait_accept();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mb_beat2_enb", sram_enb, 1);
        chk("mb_beat2_addr", sram_addrb, 12'h302);
        rst = 1'b1;
        #1;
        chk("mb_enb_drop", sram_enb, 0);
        chk("mb_rsp_drop", bus.rsp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("mb_post_enb", sram_enb, 0);
            chk("mb_post_rsp", bus.rsp_valid, 0);
            chk("mb_post_ena", sram_ena, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
